mux_sequencer: RTL and testbench
================================

Name: mux_sequencer

Overview:
- Sequences the 8-line LED multiplexer for one angular slice of the POV display.
- Per row: requests row data from the LED driver interface, waits for a ready handshake, energises exactly one mux line for a bounded drive window, then blanks all lines for a dead time before the next row.
- Sits between the rotation/slice timing logic and the LED driver block; it is the sole owner of the mux lines.
- Hard-enforces the 10 µs overdrive limit.

Parameters:
- NB_MUX, 8, number of mux lines (rows per slice); power of two, ≥2.
- DRIVE_CYCLES, 500, clk_50 cycles a mux line stays on (500 = 10 µs); must be ≥1 and ≤500.
- DEAD_CYCLES, 10, all-off cycles after each drive window (anti-ghosting); must be ≥1.
- LOAD_TIMEOUT, 1000, max clk_50 cycles to wait for drv_ready per row.

Ports:
- clk_50  in  1  50 MHz system clock
- nrst  in  1  asynchronous active-low reset
- enable  in  1  sequencer enabled; low forces all lines off
- slice_start  in  1  one-cycle pulse: begin a new slice
- drv_ready  in  1  driver has latched data for row_idx
- err_clr  in  1  one-cycle pulse: clear sticky error flags
- mux_out  out  NB_MUX  one-hot or zero mux line drive
- drv_load  out  1  request driver to load row row_idx (level)
- row_idx  out  $clog2(NB_MUX)  current row
- busy  out  1  high whenever state ≠ IDLE
- slice_done  out  1  one-cycle pulse after the last row's dead time
- err_overrun  out  1  sticky: slice_start received while busy
- err_timeout  out  1  sticky: drv_ready not received within LOAD_TIMEOUT

Behaviour:
- Reset (async, nrst low):
  - State IDLE, all counters 0.
  - mux_out=0, drv_load=0, row_idx=0, busy=0, slice_done=0, both errors 0.
- All outputs are registered.
- Invariant: mux_out is nonzero only in DRIVE, and holds at most one set bit.
- States:
  - IDLE: busy=0. slice_start && enable → LOAD with row_idx=0 on the next cycle. slice_start with enable low is ignored, with no error.
  - LOAD: drv_load=1. The cycle drv_ready is sampled high → DRIVE, and mux_out=1<<row_idx from the next cycle. If the wait counter reaches LOAD_TIMEOUT-1 with no ready → set err_timeout, abort to IDLE, no slice_done, row_idx=0.
  - DRIVE: drv_load=0, mux_out=1<<row_idx for exactly DRIVE_CYCLES consecutive cycles → DEAD.
  - DEAD: mux_out=0 for exactly DEAD_CYCLES cycles. Then:
    - if row_idx=NB_MUX-1 → IDLE, row_idx=0, slice_done=1 for one cycle;
    - else row_idx+1 → LOAD.
- Latency: slice_start at cycle 0 → drv_load high at cycle 1.
- Drive window: drv_ready sampled at cycle t → mux_out on for cycles t+1 .. t+DRIVE_CYCLES.
- Boundary conditions:
  - Counters: single shared counter, width $clog2(max(DRIVE_CYCLES,DEAD_CYCLES,LOAD_TIMEOUT)+1). Cleared on every state entry, with no wrap.
  - slice_start while busy: set err_overrun, ignore the pulse; the current slice continues unchanged.
  - enable low in any non-IDLE state: the next cycle goes to IDLE with mux_out=0, drv_load=0 and row_idx=0. No slice_done, no error.
  - drv_ready outside LOAD: ignored.
  - err_clr in the same cycle as a new error event: set wins.
  - Reset mid-DRIVE: mux_out drops asynchronously to 0.

Decomposition:
- Package mux_pkg holds:
  - state enum mux_state_t {IDLE, LOAD, DRIVE, DEAD};
  - localparams CLK_PERIOD_NS=20 and MAX_DRIVE_CYCLES=500.
- The module checks DRIVE_CYCLES ≤ MAX_DRIVE_CYCLES at elaboration.
- No sub-module; the one-hot decode is a single expression.

Test Plan (bench params: NB_MUX=8, DRIVE_CYCLES=4, DEAD_CYCLES=2, LOAD_TIMEOUT=6):
1. Nominal slice: enable=1, slice_start at cycle 0, drv_ready pulsed each time drv_load rises one cycle later → mux_out walks 0x01..0x80, each on exactly 4 cycles with 2 zero cycles between; slice_done pulses once after row 7's dead time; busy then 0.
2. Ready stall: drv_ready for row 3 delayed 5 cycles → mux_out stays 0 and drv_load stays 1 for those cycles; the row-3 window is still exactly 4 cycles; no error.
3. Timeout: drv_ready never given for row 2 → err_timeout=1 after 6 LOAD cycles; state IDLE; mux_out=0; no slice_done. A subsequent slice_start runs normally with err_timeout still 1, until err_clr clears it.
4. Overrun: second slice_start during row 4 DRIVE → err_overrun=1; rows 4..7 complete unchanged; exactly one slice_done.
5. Disable mid-drive: enable low during row 5 DRIVE → mux_out=0 next cycle, busy=0, row_idx=0, no slice_done, errors unchanged.
6. Async reset mid-DRIVE: nrst low between clock edges → mux_out=0 immediately. Assertion checked in every test: mux_out always has at most one bit set, and any single line is never high for more than 4 consecutive cycles.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types and limits for the POV row multiplexer sequencer.
// Holds the FSM state encoding and the hard LED overdrive ceiling.
package mux_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRIVE,
        DEAD
    } mux_state_t;

    localparam int CLK_PERIOD_NS    = 20;
    localparam int MAX_DRIVE_CYCLES = 500;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/mux_sequencer_if.sv
// Control/status bundle between slice timing, LED driver and the mux sequencer.
// master = sequencer side, slave = the surrounding logic that drives its inputs.
interface mux_sequencer_if #(
    parameter int NB_MUX = 8
);
    localparam int RW = $clog2(NB_MUX);

    logic              enable;
    logic              slice_start;
    logic              drv_ready;
    logic              err_clr;
    logic [NB_MUX-1:0] mux_out;
    logic              drv_load;
    logic [RW-1:0]     row_idx;
    logic              busy;
    logic              slice_done;
    logic              err_overrun;
    logic              err_timeout;

    modport master (
        input  enable, slice_start, drv_ready, err_clr,
        output mux_out, drv_load, row_idx, busy, slice_done, err_overrun, err_timeout
    );

    modport slave (
        output enable, slice_start, drv_ready, err_clr,
        input  mux_out, drv_load, row_idx, busy, slice_done, err_overrun, err_timeout
    );
endinterface

// File: rtl/mux_sequencer.sv
// Walks the mux lines of one slice: load row, drive one line, blank, next row.
// slice_start -> drv_load 1 cycle later; a row stalls in LOAD until drv_ready or timeout.
module mux_sequencer
    import mux_pkg::*;
#(
    parameter int NB_MUX       = 8,
    parameter int DRIVE_CYCLES = 500,
    parameter int DEAD_CYCLES  = 10,
    parameter int LOAD_TIMEOUT = 1000
) (
    input  logic            clk_50,
    input  logic            nrst,
    mux_sequencer_if.master bus
);
    localparam int RW = $clog2(NB_MUX);
    localparam int CW = $clog2(max3(DRIVE_CYCLES, DEAD_CYCLES, LOAD_TIMEOUT) + 1);

    if (DRIVE_CYCLES < 1 || DRIVE_CYCLES > MAX_DRIVE_CYCLES) begin : g_bad_drive
        $error("DRIVE_CYCLES out of range 1..MAX_DRIVE_CYCLES");
    end
    if (DEAD_CYCLES < 1 || NB_MUX < 2 || (NB_MUX & (NB_MUX - 1)) != 0) begin : g_bad_cfg
        $error("DEAD_CYCLES must be >=1 and NB_MUX a power of two >=2");
    end

    mux_state_t        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [RW-1:0]     row_q, row_d;
    logic [NB_MUX-1:0] mux_q;
    logic              load_q, busy_q, done_q;
    logic              err_ovr_q, err_ovr_d;
    logic              err_to_q, err_to_d;
    logic              done_evt, to_evt, ovr_evt;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CW'(1);
        row_d    = row_q;
        done_evt = 1'b0;
        to_evt   = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.slice_start && bus.enable) begin
                    state_d = LOAD;
                    row_d   = '0;
                end
            end
            LOAD: begin
                // A ready on the final wait cycle still wins over the timeout.
                if (bus.drv_ready) begin
                    state_d = DRIVE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(LOAD_TIMEOUT - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    row_d   = '0;
                    to_evt  = 1'b1;
                end
            end
            DRIVE: begin
                if (cnt_q == CW'(DRIVE_CYCLES - 1)) begin
                    state_d = DEAD;
                    cnt_d   = '0;
                end
            end
            DEAD: begin
                if (cnt_q == CW'(DEAD_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (row_q == RW'(NB_MUX - 1)) begin
                        state_d  = IDLE;
                        row_d    = '0;
                        done_evt = 1'b1;
                    end else begin
                        state_d = LOAD;
                        row_d   = row_q + RW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                row_d   = '0;
            end
        endcase
        // Disable is a silent abort: no completion pulse, no error.
        if (state_q != IDLE && !bus.enable) begin
            state_d  = IDLE;
            cnt_d    = '0;
            row_d    = '0;
            done_evt = 1'b0;
            to_evt   = 1'b0;
        end
    end

    assign ovr_evt   = bus.slice_start && (state_q != IDLE);
    assign err_ovr_d = ovr_evt | (err_ovr_q & ~bus.err_clr);
    assign err_to_d  = to_evt  | (err_to_q  & ~bus.err_clr);

    always_ff @(posedge clk_50 or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            row_q     <= '0;
            mux_q     <= '0;
            load_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_ovr_q <= 1'b0;
            err_to_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            row_q     <= row_d;
            mux_q     <= (state_d == DRIVE) ? (NB_MUX'(1) << row_d) : '0;
            load_q    <= (state_d == LOAD);
            busy_q    <= (state_d != IDLE);
            done_q    <= done_evt;
            err_ovr_q <= err_ovr_d;
            err_to_q  <= err_to_d;
        end
    end

    assign bus.mux_out     = mux_q;
    assign bus.drv_load    = load_q;
    assign bus.row_idx     = row_q;
    assign bus.busy        = busy_q;
    assign bus.slice_done  = done_q;
    assign bus.err_overrun = err_ovr_q;
    assign bus.err_timeout = err_to_q;

endmodule

// File: tb/tb_mux_sequencer.sv
// Directed bench for mux_sequencer with short windows (4 drive, 2 dead, 6 load timeout).
// Outputs sampled 1 time unit after the rising edge; mux invariants monitored on every falling edge.
module tb_mux_sequencer;
    import mux_pkg::*;

    localparam int NB    = 8;
    localparam int DC    = 4;
    localparam int DEADC = 2;
    localparam int LT    = 6;

    logic clk_50 = 1'b0;
    logic nrst;
    int   n_cmp    = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;

    mux_sequencer_if #(.NB_MUX(NB)) bus ();

    mux_sequencer #(
        .NB_MUX(NB), .DRIVE_CYCLES(DC), .DEAD_CYCLES(DEADC), .LOAD_TIMEOUT(LT)
    ) dut (
        .clk_50(clk_50),
        .nrst  (nrst),
        .bus   (bus)
    );

    always #(CLK_PERIOD_NS / 2) clk_50 = ~clk_50;

    task automatic tick();
        @(posedge clk_50);
        #1;
    endtask

    task automatic monitor();
        logic [NB-1:0] prev;
        int run;
        prev = '0;
        run  = 0;
        forever begin
            @(negedge clk_50);
            if (bus.slice_done === 1'b1) done_cnt++;
            if (bus.mux_out != '0 && bus.mux_out == prev) run++;
            else run = (bus.mux_out != '0) ? 1 : 0;
            prev = bus.mux_out;
            n_cmp++;
            if ($countones(bus.mux_out) > 1 || run > DC) begin
                n_fail++;
                $display("FAIL mux_invariant: mux_out=%b run=%0d, required at most one bit and run<=%0d",
                         bus.mux_out, run, DC);
            end
        end
    endtask

    task automatic do_row();
        tick();
        bus.drv_ready = 1'b1;
        tick();
        bus.drv_ready = 1'b0;
        repeat (DC + DEADC) tick();
    endtask

    task automatic start_slice();
        bus.slice_start = 1'b1;
        tick();
        bus.slice_start = 1'b0;
    endtask

    task automatic test_reset();
        #5;
        n_cmp++;
        if ({bus.mux_out, bus.drv_load, bus.row_idx, bus.busy, bus.slice_done,
             bus.err_overrun, bus.err_timeout} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: mux=%h load=%b row=%0d busy=%b done=%b ovr=%b to=%b, required all 0",
                     bus.mux_out, bus.drv_load, bus.row_idx, bus.busy, bus.slice_done,
                     bus.err_overrun, bus.err_timeout);
        end
        tick();
        nrst = 1'b1;
        tick();
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.drv_load !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: busy=%b load=%b, required 0 0", bus.busy, bus.drv_load);
        end
    endtask

    task automatic test_slice(input string name, input int stall_row, input int stall_len);
        logic [NB-1:0] exp;
        int d0, waits;
        d0 = done_cnt;
        start_slice();
        for (int r = 0; r < NB; r++) begin
            exp   = NB'(1) << r;
            waits = (r == stall_row) ? stall_len : 1;
            n_cmp++;
            if (bus.drv_load !== 1'b1 || bus.mux_out !== '0 || bus.row_idx !== 3'(r)) begin
                n_fail++;
                $display("FAIL %s_load_row%0d: load=%b mux=%h row=%0d, required 1 00 %0d",
                         name, r, bus.drv_load, bus.mux_out, bus.row_idx, r);
            end
            for (int w = 0; w < waits; w++) begin
                tick();
                n_cmp++;
                if (bus.drv_load !== 1'b1 || bus.mux_out !== '0 || bus.err_timeout !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s_wait_row%0d: load=%b mux=%h to=%b, required 1 00 0",
                             name, r, bus.drv_load, bus.mux_out, bus.err_timeout);
                end
            end
            bus.drv_ready = 1'b1;
            tick();
            bus.drv_ready = 1'b0;
            for (int k = 0; k < DC; k++) begin
                n_cmp++;
                if (bus.mux_out !== exp || bus.drv_load !== 1'b0 || bus.err_timeout !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s_drive_row%0d_c%0d: mux=%h load=%b to=%b, required %h 0 0",
                             name, r, k, bus.mux_out, bus.drv_load, bus.err_timeout, exp);
                end
                tick();
            end
            for (int k = 0; k < DEADC; k++) begin
                n_cmp++;
                if (bus.mux_out !== '0 || bus.busy !== 1'b1 || bus.slice_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s_dead_row%0d_c%0d: mux=%h busy=%b done=%b, required 00 1 0",
                             name, r, k, bus.mux_out, bus.busy, bus.slice_done);
                end
                tick();
            end
        end
        n_cmp++;
        if (bus.slice_done !== 1'b1 || bus.busy !== 1'b0 || bus.row_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL %s_end: done=%b busy=%b row=%0d, required 1 0 0",
                     name, bus.slice_done, bus.busy, bus.row_idx);
        end
        tick();
        n_cmp++;
        if (bus.slice_done !== 1'b0 || (done_cnt - d0) != 1) begin
            n_fail++;
            $display("FAIL %s_done_pulse: done=%b pulses=%0d, required 0 and 1 pulse",
                     name, bus.slice_done, done_cnt - d0);
        end
    endtask

    task automatic test_timeout();
        int d0;
        d0 = done_cnt;
        start_slice();
        do_row();
        do_row();
        n_cmp++;
        if (bus.row_idx !== 3'd2 || bus.drv_load !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_row2_load: row=%0d load=%b, required 2 1", bus.row_idx, bus.drv_load);
        end
        repeat (LT - 1) tick();
        n_cmp++;
        if (bus.drv_load !== 1'b1 || bus.err_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_last_wait: load=%b to=%b, required 1 0", bus.drv_load, bus.err_timeout);
        end
        tick();
        n_cmp++;
        if (bus.err_timeout !== 1'b1 || bus.busy !== 1'b0 || bus.mux_out !== '0 ||
            bus.row_idx !== 3'd0 || bus.drv_load !== 1'b0 || bus.slice_done !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_abort: to=%b busy=%b mux=%h row=%0d load=%b done=%b, required 1 0 00 0 0 0",
                     bus.err_timeout, bus.busy, bus.mux_out, bus.row_idx, bus.drv_load, bus.slice_done);
        end
        tick();
        n_cmp++;
        if (done_cnt != d0) begin
            n_fail++;
            $display("FAIL timeout_no_done: pulses=%0d, required 0", done_cnt - d0);
        end
        start_slice();
        n_cmp++;
        if (bus.drv_load !== 1'b1 || bus.err_timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_restart: load=%b to=%b, required 1 1", bus.drv_load, bus.err_timeout);
        end
        repeat (NB) do_row();
        n_cmp++;
        if (bus.slice_done !== 1'b1 || bus.err_timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_sticky_slice: done=%b to=%b, required 1 1", bus.slice_done, bus.err_timeout);
        end
        tick();
        start_slice();
        repeat (LT - 1) tick();
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        n_cmp++;
        if (bus.err_timeout !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_set_wins: to=%b busy=%b, required 1 0", bus.err_timeout, bus.busy);
        end
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        n_cmp++;
        if (bus.err_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clear: to=%b, required 0", bus.err_timeout);
        end
    endtask

    task automatic test_overrun();
        int d0;
        d0 = done_cnt;
        start_slice();
        repeat (4) do_row();
        tick();
        bus.drv_ready = 1'b1;
        tick();
        bus.drv_ready = 1'b0;
        bus.slice_start = 1'b1;
        tick();
        bus.slice_start = 1'b0;
        n_cmp++;
        if (bus.err_overrun !== 1'b1 || bus.mux_out !== 8'h10 || bus.row_idx !== 3'd4) begin
            n_fail++;
            $display("FAIL overrun_flag: ovr=%b mux=%h row=%0d, required 1 10 4",
                     bus.err_overrun, bus.mux_out, bus.row_idx);
        end
        repeat (DC - 2 + DEADC + 1) tick();
        n_cmp++;
        if (bus.row_idx !== 3'd5 || bus.drv_load !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_continue: row=%0d load=%b, required 5 1", bus.row_idx, bus.drv_load);
        end
        repeat (3) do_row();
        tick();
        n_cmp++;
        if ((done_cnt - d0) != 1 || bus.busy !== 1'b0 || bus.err_overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_one_done: pulses=%0d busy=%b ovr=%b, required 1 0 1",
                     done_cnt - d0, bus.busy, bus.err_overrun);
        end
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        n_cmp++;
        if (bus.err_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_clear: ovr=%b, required 0", bus.err_overrun);
        end
    endtask

    task automatic test_disable();
        int d0;
        bus.enable = 1'b0;
        start_slice();
        bus.drv_ready = 1'b1;
        tick();
        bus.drv_ready = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.drv_load !== 1'b0 || bus.err_overrun !== 1'b0 || bus.mux_out !== '0) begin
            n_fail++;
            $display("FAIL disable_ignore_start: busy=%b load=%b ovr=%b mux=%h, required 0 0 0 00",
                     bus.busy, bus.drv_load, bus.err_overrun, bus.mux_out);
        end
        bus.enable = 1'b1;
        d0 = done_cnt;
        start_slice();
        repeat (5) do_row();
        tick();
        bus.drv_ready = 1'b1;
        tick();
        bus.drv_ready = 1'b0;
        n_cmp++;
        if (bus.mux_out !== 8'h20) begin
            n_fail++;
            $display("FAIL disable_row5_on: mux=%h, required 20", bus.mux_out);
        end
        bus.enable = 1'b0;
        tick();
        n_cmp++;
        if (bus.mux_out !== '0 || bus.busy !== 1'b0 || bus.row_idx !== 3'd0 || bus.drv_load !== 1'b0 ||
            bus.err_overrun !== 1'b0 || bus.err_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL disable_abort: mux=%h busy=%b row=%0d load=%b ovr=%b to=%b, required 00 0 0 0 0 0",
                     bus.mux_out, bus.busy, bus.row_idx, bus.drv_load, bus.err_overrun, bus.err_timeout);
        end
        tick();
        n_cmp++;
        if (done_cnt != d0) begin
            n_fail++;
            $display("FAIL disable_no_done: pulses=%0d, required 0", done_cnt - d0);
        end
        bus.enable = 1'b1;
        tick();
    endtask

    task automatic test_async_reset();
        start_slice();
        tick();
        bus.drv_ready = 1'b1;
        tick();
        bus.drv_ready = 1'b0;
        n_cmp++;
        if (bus.mux_out !== 8'h01) begin
            n_fail++;
            $display("FAIL areset_pre: mux=%h, required 01", bus.mux_out);
        end
        #3;
        nrst = 1'b0;
        #1;
        n_cmp++;
        if (bus.mux_out !== '0 || bus.busy !== 1'b0 || bus.drv_load !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_immediate: mux=%h busy=%b load=%b, required 00 0 0",
                     bus.mux_out, bus.busy, bus.drv_load);
        end
        #2;
        nrst = 1'b1;
        tick();
        n_cmp++;
        if (bus.mux_out !== '0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_after: mux=%h busy=%b, required 00 0", bus.mux_out, bus.busy);
        end
    endtask

    initial begin
        nrst            = 1'b0;
        bus.enable      = 1'b1;
        bus.slice_start = 1'b0;
        bus.drv_ready   = 1'b0;
        bus.err_clr     = 1'b0;
        fork
            monitor();
            begin
                #500000;
                $display("FAIL watchdog: simulation exceeded time budget");
                $fatal(1, "watchdog");
            end
        join_none
        test_reset();
        test_slice("nominal", -1, 1);
        test_slice("stall", 3, 5);
        test_timeout();
        test_overrun();
        test_disable();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
